// File: rtl/banner_scroller.sv
`timescale 1ns/1ps
// banner_scroller: streams one ROM row per scroll tick to a serial display.
// clk/rst_n/enable in; rom_address out, rom_data in; ser_data/ser_clk/ser_latch, busy, overrun out.
module banner_scroller #(
  parameter int ROW_COUNT  = 129,
  parameter int ROW_WIDTH  = 57,
  parameter int SCROLL_DIV = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic [7:0]           rom_address,
  input  logic [ROW_WIDTH-1:0] rom_data,
  output logic                 ser_data,
  output logic                 ser_clk,
  output logic                 ser_latch,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW = $clog2(ROW_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        div_cnt;
  logic                 tick;
  logic [ROW_WIDTH-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic [7:0]           ptr;
  logic                 last_bit;
  logic                 shifting;

  assign tick     = enable && (div_cnt == CW'(SCROLL_DIV - 1));
  assign last_bit = (bit_cnt == BW'(ROW_WIDTH - 1));
  assign shifting = (state == S_SHIFT_LO) || (state == S_SHIFT_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (tick) state_nx = S_WAIT;
      S_WAIT:     state_nx = S_CAPTURE;
      S_CAPTURE:  state_nx = S_SHIFT_LO;
      S_SHIFT_LO: state_nx = S_SHIFT_HI;
      S_SHIFT_HI: state_nx = last_bit ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ptr     <= '0;
    end else begin
      unique case (state)
        S_CAPTURE: begin
          shreg   <= rom_data;
          bit_cnt <= '0;
        end
        S_SHIFT_HI: begin
          shreg   <= {shreg[ROW_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        S_LATCH: begin
          ptr <= (ptr == 8'(ROW_COUNT - 1)) ? '0 : ptr + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // ticks are dropped while a row is in flight; remember that it happened
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // outputs decode registered state only
  assign rom_address = ptr;
  assign ser_data    = shifting && shreg[ROW_WIDTH-1];
  assign ser_clk     = (state == S_SHIFT_HI);
  assign ser_latch   = (state == S_LATCH);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_banner_scroller.sv
`timescale 1ns/1ps
// tb_banner_scroller: table vectors, random enable gating and
// hand sequences for mid-row enable drop, mid-row reset and overrun.
module tb_banner_scroller;

  localparam int RC = 129;
  localparam int W  = 57;
  localparam int DA = 200;
  localparam int DB = 100;

  logic         clk = 1'b0;
  logic         rst_n, enable, rst_nb, enb;
  logic [7:0]   addr_a, addr_b;
  logic [W-1:0] rq_a, rq_b;
  logic         sd_a, sc_a, sl_a, busy_a, ovr_a;
  logic         sd_b, sc_b, sl_b, busy_b, ovr_b;

  logic [W-1:0] rom [0:RC-1];

  always #5 clk = ~clk;

  always @(posedge clk) rq_a <= rom[addr_a];
  always @(posedge clk) rq_b <= rom[addr_b];

  banner_scroller #(.ROW_COUNT(RC), .ROW_WIDTH(W), .SCROLL_DIV(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rom_address(addr_a), .rom_data(rq_a),
    .ser_data(sd_a), .ser_clk(sc_a), .ser_latch(sl_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  banner_scroller #(.ROW_COUNT(RC), .ROW_WIDTH(W), .SCROLL_DIV(DB)) dut_b (
    .clk(clk), .rst_n(rst_nb), .enable(enb),
    .rom_address(addr_b), .rom_data(rq_b),
    .ser_data(sd_b), .ser_clk(sc_b), .ser_latch(sl_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  // display-side receiver model for dut_a
  logic [W-1:0] mw    [0:255];
  int           mbits [0:255];
  int           maddr [0:255];
  int           blq   [0:255];
  int           mn = 0;
  int           nbl = 0;
  int           nb_cur = 0;
  int           blen = 0;
  logic [W-1:0] cur = '0;
  logic         prev_sc = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nb_cur  = 0;
      cur     = '0;
      blen    = 0;
      prev_sc = 1'b0;
    end else begin
      if (sc_a && !prev_sc) begin
        cur    = {cur[W-2:0], sd_a};
        nb_cur = nb_cur + 1;
      end
      prev_sc = sc_a;
      if (busy_a) begin
        blen = blen + 1;
      end else if (blen != 0) begin
        blq[nbl] = blen;
        nbl      = nbl + 1;
        blen     = 0;
      end
      if (sl_a) begin
        mw[mn]    = cur;
        mbits[mn] = nb_cur;
        maddr[mn] = int'(addr_a);
        mn        = mn + 1;
        cur       = '0;
        nb_cur    = 0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    int         ncyc;
    logic [7:0] addr;
    logic       busy;
    logic       latch;
    logic       ovr;
  } vec_t;

  vec_t tbl [8];
  int   e_cnt;

  initial begin
    logic [7:0] kb;
    int n;
    int w;
    logic en_r;

    tbl[0] = '{1'b0, 1'b0,   3, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 500, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 199, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1,   1, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 116, 8'd0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1,   1, 8'd1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1,  82, 8'd1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1,   1, 8'd1, 1'b1, 1'b0, 1'b0};

    rom[0] = 57'h1C0_0000_0000_0000;
    for (int k = 1; k < RC; k++) begin
      kb = 8'(k);
      if (k < 64) rom[k] = 57'({8{kb}});
      else        rom[k] = 57'({$urandom(), $urandom()});
    end

    rst_n = 1'b0; enable = 1'b0;
    rst_nb = 1'b0; enb = 1'b0;
    e_cnt = 0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      rst_n  = tbl[i].rst;
      enable = tbl[i].en;
      run(tbl[i].ncyc);
      if (tbl[i].rst && tbl[i].en) e_cnt += tbl[i].ncyc;
      chk($sformatf("vec%0d_addr", i), addr_a, tbl[i].addr);
      chk($sformatf("vec%0d_busy", i), busy_a, tbl[i].busy);
      chk($sformatf("vec%0d_latch", i), sl_a, tbl[i].latch);
      chk($sformatf("vec%0d_ovr", i), ovr_a, tbl[i].ovr);
      if (i == 5) begin
        chk("row0_count", mn, 1);
        chk("row0_word", mw[0], 57'h1C0_0000_0000_0000);
        chk("row0_bits", mbits[0], W);
        chk("row0_busy_len", blq[0], 2 * W + 3);
      end
    end

    // random enable gating; a tick lands every DA enabled cycles
    w = 0;
    while (e_cnt < 130 * DA && w < 5000) begin
      n    = $urandom_range(20, 300);
      en_r = ($urandom % 4) != 0;
      if (en_r && e_cnt + n > 130 * DA) n = 130 * DA - e_cnt;
      enable = en_r;
      run(n);
      if (en_r) e_cnt += n;
      w++;
    end
    enable = 1'b0;
    w = 0;
    while ((busy_a || mn < e_cnt / DA) && w < 400) begin
      run(1);
      w++;
    end
    chk("p2_timeout", w < 400, 1);
    chk("p2_rows", mn, e_cnt / DA);
    for (int i = 0; i < 130; i++) begin
      chk($sformatf("row%0d_word", i), mw[i], rom[i % RC]);
      chk($sformatf("row%0d_addr", i), maddr[i], i % RC);
      chk($sformatf("row%0d_shape", i),
          (mbits[i] == W) && (blq[i] == 2 * W + 3), 1);
    end
    chk("p2_addr_wrap", addr_a, 1);

    // enable dropped at bit 20
    enable = 1'b1;
    run(199);
    chk("p3_busy_pre", busy_a, 0);
    run(1);
    chk("p3_busy_go", busy_a, 1);
    run(42);
    chk("p3_bits_at_drop", nb_cur, 20);
    enable = 1'b0;
    run(120);
    chk("p3_busy_end", busy_a, 0);
    chk("p3_rows", mn, 131);
    chk("p3_word", mw[130], rom[1]);
    chk("p3_bits", mbits[130], W);
    run(400);
    chk("p3_no_tick_rows", mn, 131);
    chk("p3_no_tick_busy", busy_a, 0);
    enable = 1'b1;
    run(157);
    chk("p3_resume_pre", busy_a, 0);
    run(1);
    chk("p3_resume_go", busy_a, 1);

    // reset at bit 30
    run(62);
    chk("p4_bits", nb_cur, 30);
    chk("p4_addr_pre", addr_a, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("p4_outs_zero", {sd_a, sc_a, sl_a, busy_a, ovr_a}, 0);
    chk("p4_addr_zero", addr_a, 0);
    run(3);
    chk("p4_no_latch", mn, 131);
    rst_n = 1'b1;
    run(316);
    chk("p4_latch", sl_a, 1);
    chk("p4_latch_addr", addr_a, 0);
    run(1);
    chk("p4_rows", mn, 132);
    chk("p4_word", mw[131], rom[0]);
    chk("p4_word_bits", mbits[131], W);
    chk("p4_addr_next", addr_a, 1);
    enable = 1'b0;

    // short tick period on dut_b
    rst_nb = 1'b1;
    enb = 1'b1;
    run(199);
    chk("p5_busy1", busy_b, 1);
    chk("p5_ovr_pre", ovr_b, 0);
    run(1);
    chk("p5_ovr_set", ovr_b, 1);
    run(17);
    chk("p5_idle", busy_b, 0);
    chk("p5_addr1", addr_b, 1);
    run(82);
    chk("p5_no_extra_busy", busy_b, 0);
    chk("p5_no_extra_addr", addr_b, 1);
    run(118);
    chk("p5_addr2", addr_b, 2);
    chk("p5_ovr_sticky", ovr_b, 1);
    #2;
    rst_nb = 1'b0;
    #1;
    chk("p5_ovr_reset", ovr_b, 0);
    chk("p5_addr_reset", addr_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banner_scroller.md
BANNER_SCROLLER -- requirements
Module: banner_scroller

Interface
REQ-001 SHALL have parameter ROW_COUNT, default 129, number of banner rows held in the row ROM (addresses 0..ROW_COUNT-1).
REQ-002 SHALL have parameter ROW_WIDTH, default 57, bits per ROM row.
REQ-003 SHALL have parameter SCROLL_DIV, default 1000000, clk cycles between scroll steps; legal range >= 2*ROW_WIDTH+8.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  scrolling enabled when high.
REQ-008 rom_address  output  8  row address to the row ROM (the ROM registers it internally).
REQ-009 rom_data  input  ROW_WIDTH  row data from the ROM, valid one clk after rom_address is presented.
REQ-010 ser_data  output  1  serial pixel data to display shift register, MSB (bit ROW_WIDTH-1) first.
REQ-011 ser_clk  output  1  serial shift clock; display samples ser_data on its rising edge.
REQ-012 ser_latch  output  1  one-cycle pulse transferring the shifted row to display outputs.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 overrun  output  1  sticky flag: scroll tick arrived while busy.

Function
REQ-015 SHALL hold row pointer ptr (8 bits); rom_address SHALL equal ptr at all times (registered, no combinational path from inputs).
REQ-016 SHALL run tick counter 0..SCROLL_DIV-1 only while enable=1; tick asserted for one cycle when counter = SCROLL_DIV-1, counter then wraps to 0; counter holds value while enable=0.
REQ-017 SHALL implement FSM states IDLE, WAIT, CAPTURE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-018 IDLE -> WAIT on tick; otherwise stay IDLE.
REQ-019 WAIT: one cycle covering ROM read latency -> CAPTURE.
REQ-020 CAPTURE: load rom_data into ROW_WIDTH-bit shift register, clear bit counter -> SHIFT_LO.
REQ-021 SHIFT_LO: ser_clk=0, ser_data=shift register MSB -> SHIFT_HI.
REQ-022 SHIFT_HI: ser_clk=1, ser_data unchanged; on exit shift register shifts left by one (zero fill), bit counter increments; -> LATCH when bit counter reaches ROW_WIDTH-1 before increment, else -> SHIFT_LO.
REQ-023 LATCH: ser_latch=1 for exactly one cycle, ptr increments, wrapping from ROW_COUNT-1 to 0 -> IDLE.
REQ-024 Total row time SHALL be 2*ROW_WIDTH+3 cycles from tick to return to IDLE (117 at default).
REQ-025 ser_data SHALL be 0 and ser_clk 0 in all states except SHIFT_LO/SHIFT_HI.
REQ-026 Tick while busy SHALL be dropped (no queueing) and SHALL set overrun; overrun clears only on reset.
REQ-027 enable falling mid-row SHALL NOT abort the row: FSM completes through LATCH, then remains IDLE.
REQ-028 ptr SHALL never take a value >= ROW_COUNT.

Reset
REQ-029 rst_n low SHALL immediately, independent of clk, force: state IDLE, ptr 0, rom_address 0, tick counter 0, shift register 0, bit counter 0, ser_data 0, ser_clk 0, ser_latch 0, busy 0, overrun 0.
REQ-030 Reset asserted mid-row SHALL abandon the row with no ser_latch pulse; after release, first row sent is ptr 0.
REQ-031 Release of rst_n is synchronised externally; block SHALL act on first clk edge after release.

Verification
REQ-032 SCROLL_DIV=200, enable=1, ROM model row0=57'h1C0_0000_0000_0000 (bits 56..54 set): after tick -> 57 ser_clk rising edges, ser_data sampled sequence 1,1,1 then 54 zeros, one ser_latch pulse, busy high 117 cycles, rom_address 1 afterwards.
REQ-033 Run ROW_COUNT+1 ticks -> rom_address sequence 0,1,...,128,0; 130th row transmits ROM row 0 again.
REQ-034 SCROLL_DIV=100 (tick period shorter than 117-cycle row) -> overrun=1 after second tick, dropped tick produces no extra row; overrun stays 1 until rst_n.
REQ-035 enable dropped at bit 20 of a row -> remaining 37 bits and ser_latch still emitted, then busy=0 and no further ticks; re-enable resumes tick counter from held value.
REQ-036 rst_n pulsed low at bit 30 (between clk edges) -> all outputs 0 immediately, no ser_latch; next row after release reads address 0.
REQ-037 ROM model with 1-cycle registered latency, row k = k replicated pattern -> captured shift register equals ROM row at ptr for every row (no off-by-one from latency).
